pll_rst_seq: RTL and testbench

Reset sequencer that sits directly downstream of the clock-generation PLL wrapper. It watches the PLL `locked` flag, synchronises and qualifies it, and drives the PLL reset. It releases four per-domain resets in a fixed order, one for each PLL output clock domain, and reports lock-loss and lock-timeout events. It runs on the buffered board input clock, so it keeps operating while the PLL is unlocked.

---
 rtl/pll_rst_seq.sv | 154 +++++++++++++++
 tb/tb_pll_rst_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the clock-generation PLL: qualifies the PLL lock flag,
// drives the PLL reset and releases four per-domain resets in a fixed order.
module pll_rst_seq #(
   parameter int SYNC_STAGES     = 2,
   parameter int PLL_RST_CYC     = 8,
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int STAGE_GAP       = 16,
   parameter int LOCK_TIMEOUT    = 65536
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       locked,
   output logic       pll_rst,
   output logic [3:0] rst_out,
   output logic       ready,
   output logic [7:0] lost_cnt,
   output logic       timeout_err
);

   localparam int MAX_AB  = (PLL_RST_CYC > LOCK_STABLE_CYC) ? PLL_RST_CYC : LOCK_STABLE_CYC;
   localparam int MAX_CD  = (STAGE_GAP > LOCK_TIMEOUT) ? STAGE_GAP : LOCK_TIMEOUT;
   localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      PLLRST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [1:0]             stage, stage_nxt;
   logic [SYNC_STAGES-1:0] locked_sync;
   logic                   locked_s;
   logic                   pll_rst_nxt;
   logic [3:0]             rst_out_nxt;
   logic                   ready_nxt;
   logic [7:0]             lost_cnt_nxt;
   logic                   timeout_err_nxt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign locked_s = locked_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         locked_sync <= '0;
         state       <= PLLRST;
         cnt         <= '0;
         stage       <= 2'd0;
         pll_rst     <= 1'b1;
         rst_out     <= 4'b1111;
         ready       <= 1'b0;
         lost_cnt    <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         locked_sync <= {locked_sync[SYNC_STAGES-2:0], locked};
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         stage       <= stage_nxt;
         pll_rst     <= pll_rst_nxt;
         rst_out     <= rst_out_nxt;
         ready       <= ready_nxt;
         lost_cnt    <= lost_cnt_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      stage_nxt       = stage;
      pll_rst_nxt     = pll_rst;
      rst_out_nxt     = rst_out;
      ready_nxt       = ready;
      lost_cnt_nxt    = lost_cnt;
      timeout_err_nxt = timeout_err;
      case (state)
         PLLRST: begin
            pll_rst_nxt = 1'b1;
            if (cnt == PLL_LAST) begin
               state_nxt   = WAIT_LOCK;
               cnt_nxt     = '0;
               pll_rst_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               timeout_err_nxt = 1'b1;
               state_nxt       = PLLRST;
               cnt_nxt         = '0;
               pll_rst_nxt     = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STABLE: begin
            // A drop here is a failed qualification, not a lock loss.
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
               stage_nxt = 2'd0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RELEASE, RUN: begin
            if (!locked_s) begin
               rst_out_nxt  = 4'b1111;
               ready_nxt    = 1'b0;
               lost_cnt_nxt = sat_inc(lost_cnt);
               state_nxt    = PLLRST;
               pll_rst_nxt  = 1'b1;
               cnt_nxt      = '0;
            end else if (state == RELEASE) begin
               if (cnt == GAP_LAST) begin
                  rst_out_nxt[stage] = 1'b0;
                  cnt_nxt            = '0;
                  stage_nxt          = stage + 2'd1;
                  if (stage == 2'd3) begin
                     ready_nxt = 1'b1;
                     state_nxt = RUN;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = PLLRST;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq using the small test-plan parameter set;
// outputs are sampled on the falling edge, inputs change on the falling edge.
module tb_pll_rst_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       locked;
   logic       pll_rst;
   logic [3:0] rst_out;
   logic       ready;
   logic [7:0] lost_cnt;
   logic       timeout_err;

   int n_chk  = 0;
   int n_fail = 0;

   pll_rst_seq #(
      .SYNC_STAGES    (2),
      .PLL_RST_CYC    (4),
      .LOCK_STABLE_CYC(8),
      .STAGE_GAP      (4),
      .LOCK_TIMEOUT   (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .locked     (locked),
      .pll_rst    (pll_rst),
      .rst_out    (rst_out),
      .ready      (ready),
      .lost_cnt   (lost_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Release schedule relative to the first edge that samples locked=1.
   function automatic logic [3:0] exp_rst(input int j);
      logic [3:0] r;
      r = 4'b1111;
      for (int i = 0; i < 4; i++)
         if (j >= 14 + 4 * i) r[i] = 1'b0;
      return r;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
      check({tag, ".rst_out"}, 32'(rst_out), 32'hF);
      check({tag, ".ready"}, 32'(ready), 32'd0);
      check({tag, ".lost_cnt"}, 32'(lost_cnt), 32'd0);
      check({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
   endtask

   task automatic apply_reset();
      reset  = 1'b1;
      locked = 1'b0;
      @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
   endtask

   task automatic pll_rst_window(input string tag);
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         check(tag, 32'(pll_rst), 32'(e < 4));
      end
   endtask

   task automatic bringup(input string tag);
      locked = 1'b1;
      for (int j = 0; j <= 27; j++) begin
         @(negedge clk);
         check({tag, ".rst_out"}, 32'(rst_out), 32'(exp_rst(j)));
         check({tag, ".ready"}, 32'(ready), 32'(j >= 26));
         check({tag, ".pll_rst"}, 32'(pll_rst), 32'd0);
      end
   endtask

   task automatic lose_from_run(input string tag, input int exp_lost);
      locked = 1'b0;
      for (int e = 0; e <= 1; e++) begin
         @(negedge clk);
         check({tag, ".hold_rst"}, 32'(rst_out), 32'h0);
         check({tag, ".hold_ready"}, 32'(ready), 32'd1);
      end
      @(negedge clk);
      check({tag, ".rst_out"}, 32'(rst_out), 32'hF);
      check({tag, ".ready"}, 32'(ready), 32'd0);
      check({tag, ".lost_cnt"}, 32'(lost_cnt), 32'(exp_lost));
      check({tag, ".pll_rst"}, 32'(pll_rst), 32'd1);
      for (int e = 3; e <= 6; e++) begin
         @(negedge clk);
         check({tag, ".pll_rst_win"}, 32'(pll_rst), 32'(e <= 5));
      end
   endtask

   initial begin
      reset  = 1'b1;
      locked = 1'b0;
      repeat (2) @(negedge clk);

      // Clean bring-up
      apply_reset();
      pll_rst_window("bringup.pll_rst");
      bringup("bringup");
      check("bringup.lost_cnt", 32'(lost_cnt), 32'd0);

      // Lock loss in RUN, then re-lock replays the bring-up
      lose_from_run("loss_run", 1);
      bringup("relock");

      // Lock loss mid-RELEASE, after rst_out[1] releases
      lose_from_run("loss_run2", 2);
      locked = 1'b1;
      for (int j = 0; j <= 18; j++) @(negedge clk);
      check("midrel.released", 32'(rst_out), 32'hC);
      locked = 1'b0;
      for (int e = 0; e <= 1; e++) begin
         @(negedge clk);
         check("midrel.hold", 32'(rst_out), 32'hC);
      end
      @(negedge clk);
      check("midrel.rst_out", 32'(rst_out), 32'hF);
      check("midrel.lost_cnt", 32'(lost_cnt), 32'd3);
      check("midrel.pll_rst", 32'(pll_rst), 32'd1);
      repeat (4) @(negedge clk);
      check("midrel.pll_rst_low", 32'(pll_rst), 32'd0);

      // Glitchy lock: high 5, low 1, then high
      locked = 1'b1;
      for (int j = 0; j <= 33; j++) begin
         @(negedge clk);
         if (j == 4) locked = 1'b0;
         if (j == 5) locked = 1'b1;
         check("glitch.rst_out", 32'(rst_out), 32'(exp_rst(j - 6)));
         check("glitch.ready", 32'(ready), 32'(j - 6 >= 26));
      end
      check("glitch.lost_cnt", 32'(lost_cnt), 32'd3);

      // No lock: periodic PLL reset and sticky timeout
      apply_reset();
      for (int e = 1; e <= 76; e++) begin
         @(negedge clk);
         check("nolock.pll_rst", 32'(pll_rst), 32'((e < 4) || (((e - 4) % 36) >= 32)));
         check("nolock.timeout_err", 32'(timeout_err), 32'(e >= 36));
         check("nolock.rst_out", 32'(rst_out), 32'hF);
      end

      // Saturation: 300 losses, each taken in RELEASE
      for (int i = 0; i < 300; i++) begin
         locked = 1'b1;
         repeat (11) @(negedge clk);
         locked = 1'b0;
         repeat (3) @(negedge clk);
         check("sat.lost_cnt", 32'(lost_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
         repeat (4) @(negedge clk);
      end
      check("sat.timeout_sticky", 32'(timeout_err), 32'd1);

      // Reset asserted in RUN
      bringup("final");
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("run_reset");
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
